// File: rtl/bf_dcache_pkg.sv
// Shared op codes, FSM state encoding and address helpers for the BF data cache.
package bf_dcache_pkg;

  localparam int OP_BITS    = 3;
  localparam int STATE_BITS = 3;

  localparam logic [OP_BITS-1:0] OP_READ      = 3'd0;
  localparam logic [OP_BITS-1:0] OP_WRITE     = 3'd1;
  localparam logic [OP_BITS-1:0] OP_ADD       = 3'd2;
  localparam logic [OP_BITS-1:0] OP_FLUSH     = 3'd3;
  localparam logic [OP_BITS-1:0] OP_FLUSH_INV = 3'd4;

  typedef enum logic [STATE_BITS-1:0] {
    S_IDLE, S_LOOKUP, S_WB, S_WB_WAIT, S_FILL, S_FILL_WAIT, S_FL_SCAN, S_FL_WAIT
  } state_e;

  // Line index: low index_bits of the address (caller narrows the result).
  function automatic logic [31:0] idx_of(input logic [31:0] a, input int index_bits);
    return a & ((32'd1 << index_bits) - 32'd1);
  endfunction

  // Tag: address bits above the index (caller narrows the result).
  function automatic logic [31:0] tag_of(input logic [31:0] a, input int index_bits);
    return a >> index_bits;
  endfunction

endpackage

// File: rtl/bf_dcache_array.sv
// Line storage: data/tag arrays plus valid/dirty bit vectors, one read and one write port.
module bf_dcache_array
  import bf_dcache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic                  wr_valid_en_i,
  input  logic                  wr_valid_i,
  input  logic                  wr_dirty_en_i,
  input  logic                  wr_dirty_i,
  input  logic                  wr_tag_en_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic                  wr_data_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]                 valid_q, dirty_q;
  logic [LINES-1:0][TAG_BITS-1:0]   tag_q;
  logic [LINES-1:0][DATA_WIDTH-1:0] data_q;

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Status bits: cleared on reset so every line starts invalid and clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_valid_en_i) valid_q[wr_idx_i] <= wr_valid_i;
      if (wr_dirty_en_i) dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Payload: contents are meaningless until valid, so no reset.
  always_ff @(posedge clk) begin
    if (wr_tag_en_i)  tag_q[wr_idx_i]  <= wr_tag_i;
    if (wr_data_en_i) data_q[wr_idx_i] <= wr_data_i;
  end

endmodule

// File: rtl/bf_dcache_wb.sv
// Direct-mapped write-back cache: FSM, hit/miss counters and memory req/done handshake.
module bf_dcache_wb
  import bf_dcache_pkg::*;
#(
  parameter int ADDR_BITS  = 15,
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_BITS = 3,
  parameter int STAT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic [OP_BITS-1:0]    op_i,
  input  logic [ADDR_BITS-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rzero_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_BITS-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_done_i,
  output logic [STAT_BITS-1:0]  hit_count_o,
  output logic [STAT_BITS-1:0]  miss_count_o
);
  localparam int IW    = INDEX_BITS;
  localparam int TW    = ADDR_BITS - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  state_e                state_q, state_d;
  logic [OP_BITS-1:0]    op_q, op_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  retry_q, retry_d, done_q, done_d;
  logic [IW-1:0]         fl_q, fl_d;
  logic                  mreq_q, mreq_d, mwe_q, mwe_d;
  logic [ADDR_BITS-1:0]  maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;
  logic [STAT_BITS-1:0]  hit_q, hit_d, miss_q, miss_d;

  logic [IW-1:0]         a_idx, cur_idx;
  logic [TW-1:0]         a_tag, rd_tag;
  logic                  rd_valid, rd_dirty, hit, fl_last, mem_ack, do_alloc;
  logic [DATA_WIDTH-1:0] rd_data, wr_data;
  logic                  wr_valid_en, wr_valid, wr_dirty_en, wr_dirty, wr_tag_en, wr_data_en;

  assign a_idx   = IW'(idx_of(32'(addr_q), INDEX_BITS));
  assign a_tag   = TW'(tag_of(32'(addr_q), INDEX_BITS));
  assign cur_idx = (state_q == S_FL_SCAN || state_q == S_FL_WAIT) ? fl_q : a_idx;
  assign hit     = rd_valid && (rd_tag == a_tag);
  assign fl_last = (fl_q == IW'(LINES - 1));
  // A stray mem_done with no request outstanding is ignored.
  assign mem_ack = mem_done_i && mreq_q;

  bf_dcache_array #(.INDEX_BITS(IW), .TAG_BITS(TW), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk(clk), .reset(reset),
    .rd_idx_i(cur_idx), .rd_valid_o(rd_valid), .rd_dirty_o(rd_dirty),
    .rd_tag_o(rd_tag), .rd_data_o(rd_data),
    .wr_idx_i(cur_idx), .wr_valid_en_i(wr_valid_en), .wr_valid_i(wr_valid),
    .wr_dirty_en_i(wr_dirty_en), .wr_dirty_i(wr_dirty),
    .wr_tag_en_i(wr_tag_en), .wr_tag_i(a_tag),
    .wr_data_en_i(wr_data_en), .wr_data_i(wr_data)
  );

  // Next-state, array write controls and registered outputs.
  always_comb begin
    state_d = state_q;  op_d = op_q;  addr_d = addr_q;  wdata_d = wdata_q;
    retry_d = retry_q;  fl_d = fl_q;  done_d = 1'b0;    rdata_d = rdata_q;
    mreq_d = mreq_q;    mwe_d = mwe_q; maddr_d = maddr_q; mwdata_d = mwdata_q;
    hit_d = hit_q;      miss_d = miss_q;
    wr_valid_en = 1'b0; wr_valid = 1'b0; wr_dirty_en = 1'b0; wr_dirty = 1'b0;
    wr_tag_en = 1'b0;   wr_data_en = 1'b0; wr_data = wdata_q; do_alloc = 1'b0;
    unique case (state_q)
      S_IDLE: if (req_i) begin
        op_d    = (op_i > OP_FLUSH_INV) ? OP_READ : op_i;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        retry_d = 1'b0;
        fl_d    = '0;
        state_d = (op_i == OP_FLUSH || op_i == OP_FLUSH_INV) ? S_FL_SCAN : S_LOOKUP;
      end
      S_LOOKUP: if (hit) begin
        if (!retry_q && hit_q != '1) hit_d = hit_q + 1'b1;
        rdata_d = rd_data;
        if (op_q == OP_WRITE || op_q == OP_ADD) begin
          wr_data     = (op_q == OP_ADD) ? rd_data + wdata_q : wdata_q;
          wr_data_en  = 1'b1;
          wr_dirty_en = 1'b1;
          wr_dirty    = 1'b1;
          rdata_d     = wr_data;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        if (!retry_q && miss_q != '1) miss_d = miss_q + 1'b1;
        // A valid line that misses necessarily has a different tag.
        if (rd_valid && rd_dirty)  state_d = S_WB;
        else if (op_q == OP_WRITE) do_alloc = 1'b1;
        else                       state_d = S_FILL;
      end
      S_WB: begin
        mreq_d   = 1'b1;
        mwe_d    = 1'b1;
        maddr_d  = {rd_tag, a_idx};
        mwdata_d = rd_data;
        state_d  = S_WB_WAIT;
      end
      S_WB_WAIT: if (mem_ack) begin
        mreq_d      = 1'b0;
        wr_dirty_en = 1'b1;
        if (op_q == OP_WRITE) do_alloc = 1'b1;
        else                  state_d  = S_FILL;
      end
      S_FILL: begin
        mreq_d  = 1'b1;
        mwe_d   = 1'b0;
        maddr_d = addr_q;
        state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: if (mem_ack) begin
        mreq_d      = 1'b0;
        wr_data     = mem_rdata_i;
        wr_data_en  = 1'b1;
        wr_valid_en = 1'b1;
        wr_valid    = 1'b1;
        wr_tag_en   = 1'b1;
        wr_dirty_en = 1'b1;
        retry_d     = 1'b1;
        state_d     = S_LOOKUP;
      end
      S_FL_SCAN: begin
        // Valid is dropped on visit; the write-back uses the registered copy.
        if (op_q == OP_FLUSH_INV) wr_valid_en = 1'b1;
        if (rd_valid && rd_dirty) begin
          mreq_d   = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = {rd_tag, fl_q};
          mwdata_d = rd_data;
          state_d  = S_FL_WAIT;
        end else if (fl_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          fl_d = fl_q + 1'b1;
        end
      end
      S_FL_WAIT: if (mem_ack) begin
        mreq_d      = 1'b0;
        wr_dirty_en = 1'b1;
        if (fl_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          fl_d    = fl_q + 1'b1;
          state_d = S_FL_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Write-allocate without fetching: the whole cell is overwritten anyway.
    if (do_alloc) begin
      wr_data     = wdata_q;
      wr_data_en  = 1'b1;
      wr_valid_en = 1'b1;
      wr_valid    = 1'b1;
      wr_tag_en   = 1'b1;
      wr_dirty_en = 1'b1;
      wr_dirty    = 1'b1;
      rdata_d     = wdata_q;
      done_d      = 1'b1;
      state_d     = S_IDLE;
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  op_q <= OP_READ; addr_q <= '0; wdata_q <= '0;
      retry_q <= 1'b0;    fl_q <= '0;      done_q <= 1'b0; rdata_q <= '0;
      mreq_q  <= 1'b0;    mwe_q <= 1'b0;   maddr_q <= '0; mwdata_q <= '0;
      hit_q   <= '0;      miss_q <= '0;
    end else begin
      state_q <= state_d; op_q <= op_d;    addr_q <= addr_d; wdata_q <= wdata_d;
      retry_q <= retry_d; fl_q <= fl_d;    done_q <= done_d; rdata_q <= rdata_d;
      mreq_q  <= mreq_d;  mwe_q <= mwe_d;  maddr_q <= maddr_d; mwdata_q <= mwdata_d;
      hit_q   <= hit_d;   miss_q <= miss_d;
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign done_o       = done_q;
  assign rdata_o      = rdata_q;
  assign rzero_o      = (rdata_q == '0);
  assign mem_req_o    = mreq_q;
  assign mem_we_o     = mwe_q;
  assign mem_addr_o   = maddr_q;
  assign mem_wdata_o  = mwdata_q;
  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

endmodule
